// File: rtl/otter_io_pkg.sv
// OTTER IO constants: timer register offsets, CTRL bits, IO window.
// Shared by the timer and the top-level IOBUS read mux.
package otter_io_pkg;

  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_PRESC  = 3'd1;
  localparam logic [2:0] TMR_CMP    = 3'd2;
  localparam logic [2:0] TMR_COUNT  = 3'd3;
  localparam logic [2:0] TMR_STATUS = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam logic [31:0] TMR_BASE = 32'h1100_0100;
  localparam logic [31:0] TMR_SPAN = 32'h0000_0020;

  // Unsigned distance test: also rejects addresses below base.
  function automatic logic in_window(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    logic [31:0] rel;
    rel = addr - base;
    return rel < TMR_SPAN;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Timer prescaler: tick every presc+1 cycles while en.
// Ports: CLK, RESET, en, clr (restart), presc, tick.
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pc_q;
  logic [PRESC_W-1:0] pc_d;

  assign tick = en & ~RESET & (pc_q == presc);

  always_comb begin
    pc_d = pc_q + 1'b1;
    if (clr || !en || tick) begin
      pc_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/otter_timer_io.sv
// OTTER IOBUS timer: prescaled counter, compare, level INTR.
// Ports: CLK, RESET, IOBUS_ADDR/OUT/WR in, IOBUS_IN, IO_HIT, INTR out.
import otter_io_pkg::*;

module otter_timer_io #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int          PRESC_W   = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        IO_HIT,
  output logic        INTR
);

  logic [2:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        cmp_q, cmp_d;
  logic [31:0]        count_q, count_d;
  logic               pend_q, pend_d;

  logic [2:0] off;
  logic       wr;
  logic       wr_ctrl, wr_presc, wr_cmp;
  logic       wr_count, wr_status;
  logic       tick;
  logic       pend_set;
  logic       unused;

  assign unused = ^IOBUS_ADDR[1:0];

  assign off    = IOBUS_ADDR[4:2];
  assign IO_HIT = in_window(IOBUS_ADDR, BASE_ADDR);
  assign wr     = IOBUS_WR & IO_HIT;

  assign wr_ctrl   = wr & (off == TMR_CTRL);
  assign wr_presc  = wr & (off == TMR_PRESC);
  assign wr_cmp    = wr & (off == TMR_CMP);
  assign wr_count  = wr & (off == TMR_COUNT);
  assign wr_status = wr & (off == TMR_STATUS);

  assign INTR = pend_q & ctrl_q[CTRL_IE];

  timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .CLK  (CLK),
    .RESET(RESET),
    .en   (ctrl_q[CTRL_EN]),
    .clr  (wr_ctrl | wr_presc),
    .presc(presc_q),
    .tick (tick)
  );

  always_comb begin
    IOBUS_IN = '0;
    if (IO_HIT) begin
      case (off)
        TMR_CTRL:   IOBUS_IN = 32'(ctrl_q);
        TMR_PRESC:  IOBUS_IN = 32'(presc_q);
        TMR_CMP:    IOBUS_IN = cmp_q;
        TMR_COUNT:  IOBUS_IN = count_q;
        TMR_STATUS: IOBUS_IN = 32'(pend_q);
        default:    IOBUS_IN = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    cmp_d    = cmp_q;
    count_d  = count_q;
    pend_set = 1'b0;

    // A CPU write to COUNT suppresses this tick's compare.
    if (tick && !wr_count) begin
      if (count_q == cmp_q) begin
        pend_set = 1'b1;
        if (ctrl_q[CTRL_AUTO]) begin
          count_d = '0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_ctrl)  ctrl_d  = IOBUS_OUT[2:0];
    if (wr_presc) presc_d = IOBUS_OUT[PRESC_W-1:0];
    if (wr_cmp)   cmp_d   = IOBUS_OUT;
    if (wr_count) count_d = IOBUS_OUT;

    // New match beats a simultaneous W1C.
    pend_d = (pend_q & ~(wr_status & IOBUS_OUT[0]))
           | pend_set;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      cmp_q   <= cmp_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_otter_timer_io.sv
// Self-checking bench for otter_timer_io.
// Scoreboard of expected IOBUS reads, popped as each read settles.
module tb_otter_timer_io;

  localparam logic [31:0] B      = 32'h1100_0100;
  localparam logic [31:0] A_CTRL = B + 32'h00;
  localparam logic [31:0] A_PRE  = B + 32'h04;
  localparam logic [31:0] A_CMP  = B + 32'h08;
  localparam logic [31:0] A_CNT  = B + 32'h0C;
  localparam logic [31:0] A_STS  = B + 32'h10;

  logic        CLK;
  logic        RESET;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        IO_HIT;
  logic        INTR;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk;
  int  n_fail;

  otter_timer_io dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .IO_HIT    (IO_HIT),
    .INTR      (INTR)
  );

  initial CLK = 1'b0;
  always #50 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    cyc();
    IOBUS_WR   = 1'b0;
  endtask

  task automatic rd(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] exp
  );
    sb_t e;
    IOBUS_ADDR = a;
    IOBUS_WR   = 1'b0;
    sb_q.push_back('{tag, exp});
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, IOBUS_IN, e.exp);
    end
  endtask

  task automatic chk_intr(input string tag, input logic exp);
    #1;
    check(tag, 32'(INTR), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    RESET      = 1'b1;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    cyc();
    cyc();
    RESET = 1'b0;

    // Reset state of the whole window
    rd("rst_ctrl",  A_CTRL, 32'h0);
    rd("rst_presc", A_PRE,  32'h0);
    rd("rst_cmp",   A_CMP,  32'hFFFF_FFFF);
    rd("rst_count", A_CNT,  32'h0);
    rd("rst_stat",  A_STS,  32'h0);
    for (int i = 5; i < 8; i++) begin
      rd("rst_resv", B + 32'(i * 4), 32'h0);
    end
    chk_intr("rst_intr", 1'b0);
    rd("cmp_byteaddr", B + 32'h0A, 32'hFFFF_FFFF);
    rd("miss_data", 32'h1100_0200, 32'h0);
    check("miss_hit", 32'(IO_HIT), 32'h0);
    rd("below_data", B - 32'h4, 32'h0);
    check("below_hit", 32'(IO_HIT), 32'h0);
    rd("top_hit_data", B + 32'h1C, 32'h0);
    check("top_hit", 32'(IO_HIT), 32'h1);

    // Reserved writes ignored
    wr(B + 32'h14, 32'hDEAD_BEEF);
    rd("resv_wr", B + 32'h14, 32'h0);

    // Auto-reload: PRESC=3 CMP=4 CTRL=7
    wr(A_PRE, 32'd3);
    rd("presc_wr", A_PRE, 32'd3);
    wr(A_CMP, 32'd4);
    wr(A_CTRL, 32'h7);
    rd("ar_ctrl", A_CTRL, 32'h7);
    repeat (3) cyc();
    rd("ar_cnt_e3", A_CNT, 32'd0);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      rd("ar_cnt", A_CNT, 32'(i));
      if (i < 4) repeat (4) cyc();
    end
    repeat (3) cyc();
    rd("ar_pre_stat", A_STS, 32'd0);
    chk_intr("ar_pre_intr", 1'b0);
    cyc();
    rd("ar_stat", A_STS, 32'd1);
    rd("ar_reload", A_CNT, 32'd0);
    chk_intr("ar_intr", 1'b1);
    wr(A_STS, 32'd1);
    chk_intr("ar_w1c_intr", 1'b0);
    rd("ar_w1c_stat", A_STS, 32'd0);
    repeat (18) cyc();
    chk_intr("ar2_pre_intr", 1'b0);
    rd("ar2_cnt", A_CNT, 32'd4);
    cyc();
    chk_intr("ar2_intr", 1'b1);
    // W1C on the same edge as the next match
    repeat (19) cyc();
    wr(A_STS, 32'd1);
    rd("coll_w1c_stat", A_STS, 32'd1);
    chk_intr("coll_w1c_intr", 1'b1);
    wr(A_CTRL, 32'h0);
    wr(A_STS, 32'd1);
    chk_intr("stop_intr", 1'b0);

    // One-shot: PRESC=0 CMP=2 CTRL=5
    wr(A_CNT, 32'd0);
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h5);
    cyc();
    cyc();
    rd("os_cnt2", A_CNT, 32'd2);
    rd("os_pre_stat", A_STS, 32'd0);
    cyc();
    rd("os_stat", A_STS, 32'd1);
    rd("os_ctrl", A_CTRL, 32'h4);
    chk_intr("os_intr", 1'b1);
    repeat (10) cyc();
    rd("os_hold", A_CNT, 32'd2);
    rd("os_ctrl_hold", A_CTRL, 32'h4);

    // CTRL write beats one-shot EN clear
    wr(A_STS, 32'd1);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h5);
    cyc();
    cyc();
    wr(A_CTRL, 32'h5);
    rd("os_wr_ctrl", A_CTRL, 32'h5);
    rd("os_wr_stat", A_STS, 32'd1);
    cyc();
    rd("os_wr_ctrl2", A_CTRL, 32'h4);

    // Wrap without flag
    wr(A_STS, 32'd1);
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h1);
    rd("wr_e0", A_CNT, 32'hFFFF_FFFE);
    cyc();
    rd("wr_ff", A_CNT, 32'hFFFF_FFFF);
    cyc();
    rd("wr_0", A_CNT, 32'h0);
    rd("wr_stat0", A_STS, 32'd0);
    cyc();
    rd("wr_1", A_CNT, 32'h1);
    rd("wr_stat1", A_STS, 32'd0);

    // COUNT write on a tick cycle wins
    wr(A_CNT, 32'h100);
    rd("cw_cnt", A_CNT, 32'h100);
    cyc();
    rd("cw_inc", A_CNT, 32'h101);

    // COUNT write suppresses a pending match
    wr(A_CTRL, 32'h0);
    wr(A_CNT, 32'd5);
    wr(A_CTRL, 32'h1);
    wr(A_CNT, 32'h100);
    rd("cm_stat", A_STS, 32'd0);
    rd("cm_ctrl", A_CTRL, 32'h1);
    rd("cm_cnt", A_CNT, 32'h100);

    // Reset mid-count with INTR high
    wr(A_CTRL, 32'h0);
    wr(A_STS, 32'd1);
    wr(A_CMP, 32'd3);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h7);
    repeat (5) cyc();
    chk_intr("mr_pre_intr", 1'b1);
    rd("mr_pre_cnt", A_CNT, 32'd1);
    RESET = 1'b1;
    cyc();
    chk_intr("mr_intr", 1'b0);
    rd("mr_cnt", A_CNT, 32'd0);
    rd("mr_ctrl", A_CTRL, 32'h0);
    rd("mr_cmp", A_CMP, 32'hFFFF_FFFF);
    repeat (3) cyc();
    rd("mr_hold_cnt", A_CNT, 32'd0);
    rd("mr_hold_sts", A_STS, 32'd0);
    RESET = 1'b0;
    repeat (3) cyc();
    rd("mr_after", A_CNT, 32'd0);
    chk_intr("mr_after_intr", 1'b0);

    if (sb_q.size() != 0) begin
      check("sb_left", 32'(sb_q.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_timer_io.md
Name: otter_timer_io

Overview:
- Memory-mapped timer/interrupt peripheral; it is the responder on the OTTER IOBUS.
- Decodes CPU stores (IOBUS_ADDR, IOBUS_OUT, IOBUS_WR) into a small register file.
- Returns load data on IOBUS_IN.
- Runs a prescaled 32-bit up-counter with a compare match, and raises a level interrupt into the CPU INTR input.

Parameters:
- BASE_ADDR, 32'h1100_0100: word-aligned base of the 32-byte register window.
- PRESC_W, 16: width of the prescale register and the prescale counter.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- IOBUS_ADDR  input  32  byte address from the CPU memory stage.
- IOBUS_OUT  input  32  CPU store data.
- IOBUS_WR  input  1  store strobe, one cycle per store.
- IOBUS_IN  output  32  read data to the CPU.
- IO_HIT  output  1  high when IOBUS_ADDR falls in [BASE_ADDR, BASE_ADDR+0x1F]; used by the top-level read mux.
- INTR  output  1  interrupt request to OTTER_MCU.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RESET. All state updates on the posedge CLK.
- Register map (offset, name, access):
  - 0x00 CTRL, RW: bit0 EN, bit1 AUTO, bit2 IE; other bits read 0.
  - 0x04 PRESC, RW: [PRESC_W-1:0].
  - 0x08 CMP, RW: 32 bits.
  - 0x0C COUNT, RW: 32 bits.
  - 0x10 STATUS: bit0 PEND, write-1-to-clear.
  - 0x14..0x1C: read 0, writes ignored.
- Decode:
  - Offset = IOBUS_ADDR[4:2]. IOBUS_ADDR[1:0] is ignored.
  - Writes occur only when IOBUS_WR & IO_HIT.
- Reads:
  - IOBUS_IN is combinational from the current register values.
  - IOBUS_IN = 0 when IO_HIT = 0.
  - Zero-latency read; the CPU samples the value in the same cycle.
- Reset:
  - CTRL = 0, PRESC = 0, CMP = 32'hFFFF_FFFF, COUNT = 0, PEND = 0, prescale counter = 0.
  - INTR = 0. IOBUS_IN = 0 unless hit.
  - A reset mid-count aborts the count immediately; no interrupt survives reset.
- Prescaler:
  - The prescale counter pc increments each cycle while EN = 1.
  - tick = EN & (pc == PRESC). On tick, pc returns to 0.
  - Tick period is PRESC+1 cycles; PRESC = 0 ticks every cycle.
  - When EN = 0, pc holds at 0.
  - A write to CTRL or PRESC clears pc.
- Counter, on tick:
  - If COUNT == CMP: set PEND. Then:
    - AUTO = 1: COUNT returns to 0.
    - AUTO = 0: COUNT holds and EN clears (one-shot).
  - Otherwise COUNT = COUNT + 1, modulo 2^32. The wrap from 32'hFFFF_FFFF to 0 sets no flag.
- Interrupt:
  - INTR = PEND & IE, a level signal derived from registers.
  - INTR stays high until software clears PEND or clears IE.
- Simultaneous events:
  - CPU write to COUNT in the same cycle as a tick: the write wins, and no match is evaluated that cycle.
  - W1C of PEND in the same cycle as a new match: set wins, so PEND stays 1.
  - Write to CTRL with EN = 1 in the same cycle as a one-shot match clears EN: the CPU write wins.
  - Write to CMP: takes effect on the next tick comparison.
- Latency:
  - A register write is visible on IOBUS_IN the next cycle.
  - A match sets PEND, and INTR asserts one cycle after the tick cycle.

Decomposition:
- Package otter_io_pkg holds:
  - Register offset localparams TMR_CTRL=3'd0 .. TMR_STATUS=3'd4.
  - CTRL bit indices CTRL_EN=0, CTRL_AUTO=1, CTRL_IE=2.
  - The IO window base constants, shared by the top-level IOBUS read mux.
- One sub-module, timer_prescaler, parameterised by PRESC_W.
  - Inputs: CLK, RESET, en, clr, presc.
  - Output: tick.
- Register decode, counter and interrupt logic stay in otter_timer_io.

Test Plan:
- Reset, then read every offset 0x00..0x1C -> CTRL/PRESC/COUNT/STATUS = 0, CMP = FFFF_FFFF, reserved offsets = 0, INTR = 0. A read at 0x1100_0200 gives IO_HIT = 0 and IOBUS_IN = 0.
- Auto-reload: PRESC = 3, CMP = 4, CTRL = 0x7 -> COUNT advances every 4 cycles. PEND and INTR rise one cycle after the tick where COUNT = 4. COUNT returns to 0 and the next INTR-causing match comes 20 cycles later. W1C to STATUS drops INTR the next cycle.
- One-shot: PRESC = 0, CMP = 2, CTRL = 0x5 -> PEND is set after 3 ticks. CTRL reads 0x4 (EN cleared). COUNT holds at 2 indefinitely.
- Wrap: COUNT = FFFF_FFFE, CMP = 5, PRESC = 0, EN = 1 -> COUNT reads FFFF_FFFF, then 0, then 1, with PEND = 0 throughout.
- Collisions:
  - STATUS W1C on the same cycle as a match -> PEND stays 1.
  - Write COUNT = 0x100 on a tick cycle -> COUNT reads 0x100, not the incremented value.
- Reset asserted mid-count with PEND = 1, IE = 1 -> the next cycle INTR = 0, COUNT = 0, CTRL = 0. No tick occurs while RESET is held.
